vga_rx: RTL and testbench
=========================

# vga_rx

Pixel-stream receiver for the 640x480@60 VGA interface driven by `vga_sync` and the pattern tops. It samples H_SYNC/V_SYNC and the 5/6/5 colour lines on the pixel clock, locks onto the sync timing, and emits pixel coordinates plus RGB565 data with a valid strobe. It is used for on-chip loopback checking and as the capture end in simulation benches. It runs in the same clock domain as the transmitter, so no clock recovery or CDC is needed.

## Interface
- H_SYNC_W, 96: hsync pulse width, pixels
- H_BP, 48: horizontal back porch, pixels
- H_ACT, 640: active pixels per line
- H_TOTAL, 800: pixels per line
- V_SYNC_W, 2: vsync pulse width, lines
- V_BP, 33: vertical back porch, lines
- V_ACT, 480: active lines
- V_TOTAL, 525: lines per frame
- CLK  in  1  pixel clock; one clock, all logic on rising edge
- RST_N  in  1  reset, synchronous, active-low
- H_SYNC, V_SYNC  in  1 each  syncs, active-low pulses
- V_R  in  5  red
- V_G  in  6  green
- V_B  in  5  blue
- PIX_VALID  out  1  PIX/X/Y carry an active pixel
- X  out  10  column 0..H_ACT-1
- Y  out  10  row 0..V_ACT-1
- PIX  out  16  {R,G,B} RGB565
- FRAME_START  out  1  one-cycle pulse with pixel (0,0)
- LOCKED  out  1  timing verified, output enabled
- SYNC_ERR  out  1  one-cycle pulse on timing violation

## Operation
- Stage 1 registers all inputs. Edges are detected on the registered syncs: a fall means the previous sample was 1 and the current sample is 0.
- h_cnt (10 b):
  - Set to 0 on the sample where H_SYNC falls; otherwise increments.
  - Before it is reset, the value must be H_TOTAL-1. Anything else is a line error.
  - If h_cnt reaches H_TOTAL-1 and the next sample is not an H_SYNC fall, that is a missing-sync error. h_cnt saturates at H_TOTAL.
- V_SYNC fall sets a pending flag. The flag is applied at the next H_SYNC fall, or at the same sample if both fall together.
- v_cnt (10 b):
  - Increments at each H_SYNC fall.
  - At an H_SYNC fall with the pending flag set, v_cnt is set to 0 and the flag clears.
  - v_cnt must read V_TOTAL-1 just before that reset; otherwise it is a frame error. v_cnt saturates at V_TOTAL.
- State machine:
  - SEARCH (reset state) → ALIGN on the first applied V_SYNC event.
  - ALIGN → LOCKED on the next applied V_SYNC event, provided no error occurred during the frame in between.
  - ALIGN → SEARCH on any error.
  - LOCKED → SEARCH on any error.
  - SYNC_ERR pulses for every error detected in ALIGN or LOCKED. It never pulses in SEARCH.
- Active pixel condition: LOCKED, H_SYNC_W+H_BP ≤ h_cnt < H_SYNC_W+H_BP+H_ACT, and V_SYNC_W+V_BP ≤ v_cnt < V_SYNC_W+V_BP+V_ACT.
  - X = h_cnt−(H_SYNC_W+H_BP), Y = v_cnt−(V_SYNC_W+V_BP), PIX = {V_R,V_G,V_B}, all from the same stage-1 sample.
  - When PIX_VALID=0: X, Y and PIX hold 0.
- FRAME_START = PIX_VALID && X==0 && Y==0.
- Offsets are computed as unsigned 10-bit values; parameter sums must be ≤ 1023.

## Timing
- An input sample present in cycle N produces its output (PIX_VALID, X, Y, PIX, FRAME_START) in cycle N+2. All outputs are registered.
- LOCKED rises in the cycle after the second applied V_SYNC event is processed. It falls one cycle after an error is detected, in the same cycle as SYNC_ERR.
- PIX_VALID is forced low in the same cycle LOCKED falls.
- Reset (RST_N=0 sampled at an edge):
  - After that edge all outputs are 0, state is SEARCH, counters and the pending flag are 0.
  - Mid-frame reset requires a complete clean frame before LOCKED returns.
- Minimum lock time from a clean stream: one full frame after the first V_SYNC fall. That is H_TOTAL·V_TOTAL = 420000 cycles plus alignment.

## Test plan
- Nominal 640x480 stream from `vga_sync`:
  - LOCKED asserts after one full frame.
  - Each following frame has exactly 307200 PIX_VALID cycles.
  - The first valid cycle has FRAME_START=1, X=0, Y=0; the last has X=639, Y=479.
  - FRAME_START=1 exactly once per frame; SYNC_ERR stays 0.
- Colour bars (bar changes every 80 px, cycling through 3-bit colours):
  - X=0..79 carry one constant PIX; at X=80 PIX changes to the next bar value.
  - Each PIX value equals the driven {V_R,V_G,V_B}, with the 2-cycle latency checked.
- Short line: one 799-cycle line while LOCKED:
  - SYNC_ERR=1 for one cycle, and LOCKED=0 and PIX_VALID=0 in that same cycle.
  - LOCKED returns after the next clean frame.
- Missing hsync: H_SYNC held at 1 while LOCKED → SYNC_ERR pulses when h_cnt passes 799; state becomes SEARCH.
- Frame length: 524-line frame → SYNC_ERR pulses at the applied V_SYNC event. Simultaneous H_SYNC/V_SYNC falls are accepted as line 0.
- Reset: RST_N low for one cycle mid-line while LOCKED:
  - All outputs are 0 after that edge.
  - No PIX_VALID appears until LOCKED re-asserts.

Source files
------------

// File: rtl/vga_rx_if.sv
// Pixel-stream bundle between a VGA source and the vga_rx capture block.
// The source drives syncs and colour; the receiver returns decoded pixels.
interface vga_rx_if;
    logic        H_SYNC;
    logic        V_SYNC;
    logic [4:0]  V_R;
    logic [5:0]  V_G;
    logic [4:0]  V_B;
    logic        PIX_VALID;
    logic [9:0]  X;
    logic [9:0]  Y;
    logic [15:0] PIX;
    logic        FRAME_START;
    logic        LOCKED;
    logic        SYNC_ERR;

    modport master (
        output H_SYNC, V_SYNC, V_R, V_G, V_B,
        input  PIX_VALID, X, Y, PIX, FRAME_START, LOCKED, SYNC_ERR
    );

    modport slave (
        input  H_SYNC, V_SYNC, V_R, V_G, V_B,
        output PIX_VALID, X, Y, PIX, FRAME_START, LOCKED, SYNC_ERR
    );
endinterface

// File: rtl/vga_rx.sv
// VGA pixel-stream receiver: locks onto sync timing and emits
// pixel coordinates with RGB565 data two cycles after sampling.
module vga_rx #(
    parameter int H_SYNC_W = 96,
    parameter int H_BP     = 48,
    parameter int H_ACT    = 640,
    parameter int H_TOTAL  = 800,
    parameter int V_SYNC_W = 2,
    parameter int V_BP     = 33,
    parameter int V_ACT    = 480,
    parameter int V_TOTAL  = 525
) (
    input  logic     CLK,
    input  logic     RST_N,
    vga_rx_if.slave  bus
);

    localparam logic [9:0] H_OFF  = 10'(H_SYNC_W + H_BP);
    localparam logic [9:0] H_END  = 10'(H_SYNC_W + H_BP + H_ACT);
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_SAT  = 10'(H_TOTAL);
    localparam logic [9:0] V_OFF  = 10'(V_SYNC_W + V_BP);
    localparam logic [9:0] V_END  = 10'(V_SYNC_W + V_BP + V_ACT);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_SAT  = 10'(V_TOTAL);

    typedef enum logic [1:0] {
        S_SEARCH,
        S_ALIGN,
        S_LOCK
    } state_t;

    state_t      state_q;
    state_t      state_nxt;

    logic        hs_q;
    logic        hs_p;
    logic        vs_q;
    logic        vs_p;
    logic [15:0] rgb_q;

    logic [9:0]  h_cnt;
    logic [9:0]  v_cnt;
    logic        pend_q;

    logic        pv_q;
    logic [9:0]  x_q;
    logic [9:0]  y_q;
    logic [15:0] pix_q;
    logic        fs_q;
    logic        lock_q;
    logic        serr_q;

    logic        h_fall;
    logic        v_fall;
    logic        v_apply;
    logic        err;
    logic        err_rep;
    logic [9:0]  h_nxt;
    logic [9:0]  v_nxt;
    logic        pend_nxt;
    logic        act;
    logic [9:0]  x_nxt;
    logic [9:0]  y_nxt;

    // Stage 1: register raw inputs and keep the previous sync samples.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hs_q  <= 1'b0;
            hs_p  <= 1'b0;
            vs_q  <= 1'b0;
            vs_p  <= 1'b0;
            rgb_q <= '0;
        end else begin
            hs_p  <= hs_q;
            hs_q  <= bus.H_SYNC;
            vs_p  <= vs_q;
            vs_q  <= bus.V_SYNC;
            rgb_q <= {bus.V_R, bus.V_G, bus.V_B};
        end
    end

    assign h_fall  = hs_p & ~hs_q;
    assign v_fall  = vs_p & ~vs_q;
    assign v_apply = h_fall & (pend_q | v_fall);

    // Counters hold the position of the current stage-1 sample.
    always_comb begin
        h_nxt    = h_cnt;
        v_nxt    = v_cnt;
        pend_nxt = pend_q | v_fall;
        err      = 1'b0;
        if (h_fall) begin
            h_nxt = '0;
            err   = (h_cnt != H_LAST);
            if (v_apply) begin
                v_nxt    = '0;
                pend_nxt = 1'b0;
                err      = err | (v_cnt != V_LAST);
            end else if (v_cnt < V_SAT) begin
                v_nxt = v_cnt + 10'd1;
            end
        end else begin
            err = (h_cnt == H_LAST);
            if (h_cnt < H_SAT) begin
                h_nxt = h_cnt + 10'd1;
            end
        end
    end

    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            S_SEARCH: if (v_apply) state_nxt = S_ALIGN;
            S_ALIGN: begin
                if (err)          state_nxt = S_SEARCH;
                else if (v_apply) state_nxt = S_LOCK;
            end
            S_LOCK:   if (err) state_nxt = S_SEARCH;
            default:  state_nxt = S_SEARCH;
        endcase
    end

    assign err_rep = err & (state_q != S_SEARCH);

    assign act = (state_nxt == S_LOCK)
               & (h_nxt >= H_OFF) & (h_nxt < H_END)
               & (v_nxt >= V_OFF) & (v_nxt < V_END);

    assign x_nxt = act ? (h_nxt - H_OFF) : '0;
    assign y_nxt = act ? (v_nxt - V_OFF) : '0;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= S_SEARCH;
            h_cnt   <= '0;
            v_cnt   <= '0;
            pend_q  <= 1'b0;
            pv_q    <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            pix_q   <= '0;
            fs_q    <= 1'b0;
            lock_q  <= 1'b0;
            serr_q  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            h_cnt   <= h_nxt;
            v_cnt   <= v_nxt;
            pend_q  <= pend_nxt;
            pv_q    <= act;
            x_q     <= x_nxt;
            y_q     <= y_nxt;
            pix_q   <= act ? rgb_q : '0;
            fs_q    <= act & (x_nxt == '0) & (y_nxt == '0);
            lock_q  <= (state_nxt == S_LOCK);
            serr_q  <= err_rep;
        end
    end

    assign bus.PIX_VALID   = pv_q;
    assign bus.X           = x_q;
    assign bus.Y           = y_q;
    assign bus.PIX         = pix_q;
    assign bus.FRAME_START = fs_q;
    assign bus.LOCKED      = lock_q;
    assign bus.SYNC_ERR    = serr_q;

endmodule

// File: tb/tb_vga_rx.sv
// Bench for vga_rx on a shrunken raster: frame scenarios from a table,
// per-sample expectations queued at drive time and checked at output.
module tb_vga_rx;

    localparam int HSW = 4;
    localparam int HBP = 3;
    localparam int HA  = 16;
    localparam int HT  = 28;
    localparam int VSW = 2;
    localparam int VBP = 2;
    localparam int VA  = 6;
    localparam int VT  = 12;
    localparam int HO  = HSW + HBP;
    localparam int VO  = VSW + VBP;
    localparam int FULL = HA * VA;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    vga_rx_if bus();

    vga_rx #(
        .H_SYNC_W(HSW), .H_BP(HBP), .H_ACT(HA), .H_TOTAL(HT),
        .V_SYNC_W(VSW), .V_BP(VBP), .V_ACT(VA), .V_TOTAL(VT)
    ) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        pv;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [15:0] pix;
        logic        fs;
        logic        lk;
        logic        err;
    } obs_t;

    typedef struct {
        int nlines;
        int short_ln;
        int drop_ln;
        int rst_ln;
        int rst_h;
        int exp_pv;
        int exp_fs;
        int exp_err;
    } frm_t;

    obs_t q[$];
    frm_t tbl[17];
    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_pv = 0;
    int n_fs = 0;
    int n_err = 0;
    int last_x = 0;
    int last_y = 0;
    int vev_ok = 0;
    int prev_lines = 0;

    function automatic obs_t dut_obs();
        obs_t o;
        o.pv  = bus.PIX_VALID;
        o.x   = bus.X;
        o.y   = bus.Y;
        o.pix = bus.PIX;
        o.fs  = bus.FRAME_START;
        o.lk  = bus.LOCKED;
        o.err = bus.SYNC_ERR;
        return o;
    endfunction

    function automatic logic [15:0] bar(int x, int f);
        int c;
        c = ((x / 4) + f) % 8;
        return {{5{c[2]}}, {6{c[1]}}, {5{c[0]}}};
    endfunction

    function automatic frm_t mk(int nl, int sl, int dl, int rl, int rh,
                                int pv, int fs, int er);
        frm_t t;
        t.nlines = nl; t.short_ln = sl; t.drop_ln = dl;
        t.rst_ln = rl; t.rst_h = rh;
        t.exp_pv = pv; t.exp_fs = fs; t.exp_err = er;
        return t;
    endfunction

    task automatic cmp(string nm, int got, int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", nm, got, want);
        end
    endtask

    task automatic check_one(obs_t e);
        obs_t a;
        a = dut_obs();
        total++;
        if (a.pv) begin
            n_pv++;
            last_x = int'(a.x);
            last_y = int'(a.y);
        end
        n_fs  += int'(a.fs);
        n_err += int'(a.err);
        if (a !== e) begin
            bad++;
            $display("FAIL obs cyc=%0d got pv=%0b x=%0d y=%0d pix=%h fs=%0b lk=%0b err=%0b want pv=%0b x=%0d y=%0d pix=%h fs=%0b lk=%0b err=%0b",
                     cyc, a.pv, a.x, a.y, a.pix, a.fs, a.lk, a.err,
                     e.pv, e.x, e.y, e.pix, e.fs, e.lk, e.err);
        end
    endtask

    task automatic step(input logic hs, input logic vs,
                        input logic [15:0] rgb, input logic rn,
                        input obs_t e);
        @(negedge clk);
        cyc++;
        if (q.size() >= 2) check_one(q.pop_front());
        bus.H_SYNC = hs;
        bus.V_SYNC = vs;
        bus.V_R = rgb[15:11];
        bus.V_G = rgb[10:5];
        bus.V_B = rgb[4:0];
        rst_n = rn;
        // A reset edge also wipes the sample still in stage 1.
        if (!rn && q.size() > 0) q[q.size()-1] = '0;
        q.push_back(e);
    endtask

    task automatic run_frame(int f, frm_t t);
        int p0, f0, e0;
        p0 = n_pv; f0 = n_fs; e0 = n_err;
        for (int v = 0; v < t.nlines; v++) begin
            int len;
            len = (v == t.short_ln) ? HT - 1 : HT;
            for (int h = 0; h < len; h++) begin
                logic hs, vs, rn, cand, apos;
                logic [15:0] rgb;
                obs_t e;
                hs = (v == t.drop_ln) ? 1'b1 : (h >= HSW);
                vs = (v >= VSW);
                apos = (h >= HO) && (h < HO + HA) && (v >= VO) && (v < VO + VA);
                rgb = apos ? bar(h - HO, f) : 16'($urandom);
                rn = !(v == t.rst_ln && h == t.rst_h);
                e = '0;
                if (!rn) begin
                    vev_ok = 0;
                end else begin
                    cand = (h == 0) &&
                           ((t.short_ln >= 0 && v == t.short_ln + 1) ||
                            (v == t.drop_ln) ||
                            (v == 0 && prev_lines != VT));
                    if (cand && vev_ok >= 1) begin
                        e.err = 1'b1;
                        vev_ok = 0;
                    end else if (h == 0 && v == 0 && vev_ok < 2) begin
                        vev_ok++;
                    end
                    e.lk = (vev_ok >= 2);
                    if (e.lk && apos) begin
                        e.pv  = 1'b1;
                        e.x   = 10'(h - HO);
                        e.y   = 10'(v - VO);
                        e.pix = rgb;
                        e.fs  = (h == HO) && (v == VO);
                    end
                end
                step(hs, vs, rgb, rn, e);
            end
        end
        prev_lines = t.nlines;
        cmp($sformatf("f%0d_valid", f), n_pv - p0, t.exp_pv);
        cmp($sformatf("f%0d_fstart", f), n_fs - f0, t.exp_fs);
        cmp($sformatf("f%0d_syncerr", f), n_err - e0, t.exp_err);
    endtask

    initial begin
        tbl[0]  = mk(VT, -1, -1, -1, 0, 0, 0, 0);
        tbl[1]  = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[2]  = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[3]  = mk(VT,  4, -1, -1, 0, HA, 1, 1);
        tbl[4]  = mk(VT, -1, -1, -1, 0, 0, 0, 0);
        tbl[5]  = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[6]  = mk(VT, -1,  6, -1, 0, 2 * HA, 1, 1);
        tbl[7]  = mk(VT, -1, -1, -1, 0, 0, 0, 0);
        tbl[8]  = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[9]  = mk(VT - 1, -1, -1, -1, 0, FULL, 1, 0);
        tbl[10] = mk(VT, -1, -1, -1, 0, 0, 0, 1);
        tbl[11] = mk(VT, -1, -1, -1, 0, 0, 0, 0);
        tbl[12] = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[13] = mk(VT, -1, -1, 6, 10, 2 * HA + 2, 1, 0);
        tbl[14] = mk(VT, -1, -1, -1, 0, 0, 0, 0);
        tbl[15] = mk(VT, -1, -1, -1, 0, FULL, 1, 0);
        tbl[16] = mk(VT, -1, -1, -1, 0, FULL, 1, 0);

        bus.H_SYNC = 1'b1;
        bus.V_SYNC = 1'b1;
        bus.V_R = '0;
        bus.V_G = '0;
        bus.V_B = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        cmp("rst_valid", int'(bus.PIX_VALID), 0);
        cmp("rst_x", int'(bus.X), 0);
        cmp("rst_y", int'(bus.Y), 0);
        cmp("rst_pix", int'(bus.PIX), 0);
        cmp("rst_fstart", int'(bus.FRAME_START), 0);
        cmp("rst_locked", int'(bus.LOCKED), 0);
        cmp("rst_syncerr", int'(bus.SYNC_ERR), 0);

        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, 16'h0, 1'b1, '0);

        for (int i = 0; i < 17; i++) begin
            run_frame(i, tbl[i]);
            if (i == 2) begin
                cmp("last_x", last_x, HA - 1);
                cmp("last_y", last_y, VA - 1);
            end
        end

        while (q.size() > 0) begin
            @(negedge clk);
            cyc++;
            check_one(q.pop_front());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
